ring_reader: RTL
================

Name: ring_reader

Overview:
- Read-side (head) controller for the 4-entry MAC operand ring buffer.
- The writer owns TP and Receive handshakes. The round-flag block combines TP, HP and both handshakes into the wrap bit Round.
- This block owns HP and generates Send_Handshaking.
- It presents ring entries to the downstream MAC datapath through a registered valid/ready output stage, one entry per cycle.

Parameters:
- DATA_W, 16, width of one ring entry.
- DEPTH, 4, ring depth. Fixed at 4 to match the 2-bit TP/HP pointers; any other value is unsupported.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- TP  input  2  writer tail pointer (next slot to be written)
- Round  input  1  wrap bit from the round-flag block; 1 = writer has wrapped and reader has not
- ring_data  input  DEPTH*DATA_W  flattened ring contents; entry i occupies bits [i*DATA_W +: DATA_W]
- HP  output  2  head pointer (next slot to read)
- Send_Handshaking  output  1  pop strobe, high for each cycle in which the entry at HP is consumed
- out_valid  output  1  out_data holds a valid entry
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  DATA_W  registered entry presented downstream
- empty  output  1  ring holds no unread entries
- full  output  1  ring holds DEPTH unread entries
- level  output  3  number of unread ring entries, 0..4
- xfer_cnt  output  CNT_W  count of accepted downstream transfers

Behaviour:
- Reset (rst=1 at a clock edge):
  - HP=0, out_valid=0, out_data=0, xfer_cnt=0.
  - Send_Handshaking is forced to 0 while rst=1.
  - Reset mid-transfer discards the held entry; no pop is issued.
- Occupancy (combinational from TP, HP, Round):
  - empty = (TP==HP) && !Round
  - full = (TP==HP) && Round
  - level = Round ? (4 - HP + TP) : (TP - HP), computed in 3 bits.
- State machine, two states encoded by out_valid:
  - IDLE (out_valid=0): no entry held.
  - HOLD (out_valid=1): entry held in out_data.
- pop condition: pop = !rst && !empty && (!out_valid || out_ready). Send_Handshaking = pop.
  - Send_Handshaking is asserted in the same cycle HP still holds the slot being read. HP and Round therefore update on the same edge; the round-flag block samples HP==3 together with the strobe.
- On an edge with pop=1:
  - out_data <= ring_data entry [HP].
  - HP <= HP+1, wrapping 3 to 0 (2-bit natural wrap).
  - out_valid <= 1.
- On an edge with out_valid && out_ready && !pop: out_valid <= 0 (HOLD to IDLE).
- Transitions:
  - IDLE to HOLD on pop.
  - HOLD stays HOLD while (out_ready && pop), which reloads back-to-back, or while !out_ready.
  - HOLD to IDLE when out_ready && empty.
- Latency: entry written at edge N (TP advances) gives out_valid=1 at edge N+1 if IDLE.
- Throughput: 1 entry/cycle with out_ready held high.
- out_data and out_valid hold stable while out_valid && !out_ready (no data change under back-pressure).
- xfer_cnt increments by 1 on each edge with out_valid && out_ready and wraps at 2^CNT_W. It is unaffected by pops alone.
- Empty ring: no pop and HP holds. out_valid drops after the last accepted entry.
- Full ring: reading is allowed. The pop at HP==3 with Round=1 clears Round via the round-flag block.
- Simultaneous writer push and reader pop on the same slot:
  - Permitted only when not empty; empty is evaluated before this cycle's push.
  - A push into an empty ring is visible to the reader the following cycle.
- out_ready while out_valid=0 is ignored.
- Send_Handshaking has a combinational path from out_ready. The downstream must not drive out_ready combinationally from Send_Handshaking.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with TP=0, Round=0 -> HP=0, out_valid=0, empty=1, level=0, Send_Handshaking=0.
- Single entry: TP steps 0->1, ring_data[0]=16'h00A5, out_ready=1 -> next cycle Send_Handshaking=1, then out_data=16'h00A5, out_valid=1, HP=1, xfer_cnt=1 after accept, then out_valid=0.
- Full ring and wrap: TP=0, Round=1, entries 1,2,3,4, out_ready=1 -> full=1, level=4; four consecutive pops with out_data 1,2,3,4 on successive cycles; HP goes 0->1->2->3->0. The pop at HP=3 coincides with Send_Handshaking=1 so Round clears; ends with empty=1.
- Back-pressure: HOLD with out_data=16'h1234, out_ready=0 for 5 cycles, level=3 -> out_data stable, HP constant, Send_Handshaking=0; out_ready=1 resumes 1/cycle.
- Concurrent write and read: writer advances TP every cycle while out_ready=1 -> level stays 1, one pop per cycle, no entry skipped or duplicated over 12 transfers, xfer_cnt=12.
- Mid-operation reset: rst=1 during HOLD with level=2 -> next edge HP=0, out_valid=0, xfer_cnt=0, no Send_Handshaking pulse during rst.

Source files
------------

// File: rtl/ring_reader.sv
// Read-side (head) controller for the 4-entry MAC operand ring buffer.
// Owns the head pointer, raises Send_Handshaking for each pop and hands
// entries to the MAC datapath through a registered valid/ready stage.
module ring_reader #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              TP,
  input  logic                    Round,
  input  logic [DEPTH*DATA_W-1:0] ring_data,
  output logic [1:0]              HP,
  output logic                    Send_Handshaking,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    empty,
  output logic                    full,
  output logic [2:0]              level,
  output logic [CNT_W-1:0]        xfer_cnt
);

  // Output stage state; HOLD means out_data carries a valid entry.
  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic [1:0]          r_hp;
  logic [DATA_W-1:0]   r_data;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_pop;
  logic                w_accept;
  logic                w_ptr_eq;
  logic [1:0]          w_diff;
  logic [DATA_W-1:0]   w_entries [DEPTH];

  // Unpack the flattened ring into addressable entries.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_entries[i] = ring_data[i*DATA_W +: DATA_W];
    end
  end

  // Occupancy derived from the pointers and the wrap bit.
  always_comb begin
    w_ptr_eq = (TP == r_hp);
    w_diff   = TP - r_hp;
    empty    = w_ptr_eq && !Round;
    full     = w_ptr_eq && Round;
    level    = Round ? (3'd4 - {1'b0, r_hp} + {1'b0, TP}) : {1'b0, w_diff};
  end

  // Pop decision and next output-stage state.
  always_comb begin
    w_accept  = (r_state == StHold) && out_ready;
    w_pop     = !rst && !empty && ((r_state == StIdle) || out_ready);
    w_state_d = r_state;
    if (w_pop) begin
      w_state_d = StHold;
    end else if (w_accept) begin
      w_state_d = StIdle;
    end
  end

  // Head pointer, output register and transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_hp    <= 2'd0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_pop) begin
        r_data <= w_entries[r_hp];
        r_hp   <= r_hp + 2'd1;
      end
      if (w_accept) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Strobe is asserted while HP still addresses the slot being consumed.
  always_comb begin
    HP               = r_hp;
    Send_Handshaking = w_pop;
    out_valid        = (r_state == StHold);
    out_data         = r_data;
    xfer_cnt         = r_cnt;
  end

endmodule
